// File: rtl/milano_ctrl.sv
// Pipeline controller: boot sequencing, branch/exception redirects, load-use and
// multicycle-EX stalls, busy timeout and halt handling.
module milano_ctrl #(
   parameter logic [31:0] EXC_ADDR     = 32'h0000_0080,
   parameter int unsigned BUSY_TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_enable_i,
   input  logic [31:0] boot_addr_i,
   input  logic        branch_taken_ex_i,
   input  logic [31:0] branch_target_ex_i,
   input  logic        ex_busy_i,
   input  logic [4:0]  ex_rd_addr_i,
   input  logic        ex_rd_wr_en_i,
   input  logic        ex_is_load_i,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic        id_rs1_used_i,
   input  logic        id_rs2_used_i,
   input  logic        illegal_instr_i,
   input  logic [31:0] id_pc_i,
   output logic        pc_set_o,
   output logic [31:0] pc_addr_o,
   output logic        fetch_enable_o,
   output logic        stall_if_o,
   output logic        stall_id_o,
   output logic        flush_id_o,
   output logic        flush_ex_o,
   output logic [31:0] exc_pc_o,
   output logic        timeout_o,
   output logic [31:0] stall_cnt_o,
   output logic [2:0]  ctrl_state_o
);

   typedef enum logic [2:0] {
      StReset   = 3'd0,
      StBootSet = 3'd1,
      StRun     = 3'd2,
      StWaitEx  = 3'd3,
      StFlush   = 3'd4,
      StHalt    = 3'd5
   } state_e;

   localparam logic [8:0] TimeoutCnt = 9'(BUSY_TIMEOUT);

   state_e      state_q, state_d;
   logic [7:0]  busy_cnt_q, busy_cnt_d;
   logic        timeout_q, timeout_d;
   logic [31:0] exc_pc_q, exc_pc_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic timeout_hit;

   assign load_use = ex_is_load_i & ex_rd_wr_en_i & (ex_rd_addr_i != 5'd0) &
                     ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                      (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

   // busy_cnt_q already includes the RUN cycle that first saw ex_busy_i
   assign timeout_hit = (state_q == StWaitEx) & ex_busy_i &
                        (({1'b0, busy_cnt_q} + 9'd1) >= TimeoutCnt);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StReset;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StReset:   if (fetch_enable_i) state_d = StBootSet;
         StBootSet: state_d = StRun;
         StRun: begin
            if (branch_taken_ex_i)    state_d = StRun;
            else if (illegal_instr_i) state_d = StFlush;
            else if (ex_busy_i)       state_d = StWaitEx;
            else if (load_use)        state_d = StRun;
            else if (!fetch_enable_i) state_d = StHalt;
         end
         StWaitEx: begin
            if (!ex_busy_i)       state_d = StRun;
            else if (timeout_hit) state_d = StHalt;
         end
         StFlush: state_d = StRun;
         StHalt:  if (fetch_enable_i && !timeout_q) state_d = StRun;
         default: state_d = StReset;
      endcase
   end

   always_comb begin
      pc_set_o       = 1'b0;
      pc_addr_o      = 32'd0;
      fetch_enable_o = 1'b0;
      stall_if_o     = 1'b0;
      stall_id_o     = 1'b0;
      flush_id_o     = 1'b0;
      flush_ex_o     = 1'b0;
      unique case (state_q)
         StReset: begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
         end
         StBootSet: begin
            pc_set_o   = 1'b1;
            pc_addr_o  = boot_addr_i;
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
         end
         StRun: begin
            fetch_enable_o = 1'b1;
            if (branch_taken_ex_i) begin
               pc_set_o   = 1'b1;
               pc_addr_o  = branch_target_ex_i;
               flush_id_o = 1'b1;
               flush_ex_o = 1'b1;
            end else if (illegal_instr_i) begin
               pc_set_o   = 1'b1;
               pc_addr_o  = EXC_ADDR;
               flush_id_o = 1'b1;
               flush_ex_o = 1'b1;
            end else if (ex_busy_i) begin
               stall_if_o = 1'b1;
               stall_id_o = 1'b1;
            end else if (load_use) begin
               stall_if_o = 1'b1;
               stall_id_o = 1'b1;
               flush_ex_o = 1'b1;
            end
         end
         StWaitEx, StHalt: begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
         end
         StFlush: flush_id_o = 1'b1;
         default: begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
         end
      endcase
   end

   always_comb begin
      exc_pc_d    = exc_pc_q;
      timeout_d   = timeout_q | timeout_hit;
      busy_cnt_d  = busy_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if ((state_q == StRun) && !branch_taken_ex_i && illegal_instr_i) begin
         exc_pc_d = id_pc_i;
      end
      if (state_d == StWaitEx) begin
         busy_cnt_d = (state_q == StWaitEx) ? busy_cnt_q + 8'd1 : 8'd1;
      end else if (state_d == StRun) begin
         busy_cnt_d = 8'd0;
      end
      if (((state_q == StRun) || (state_q == StWaitEx)) && stall_id_o &&
          (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
         exc_pc_q    <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         busy_cnt_q  <= busy_cnt_d;
         timeout_q   <= timeout_d;
         exc_pc_q    <= exc_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign exc_pc_o     = exc_pc_q;
   assign timeout_o    = timeout_q;
   assign stall_cnt_o  = stall_cnt_q;
   assign ctrl_state_o = state_q;

endmodule

// File: doc/milano_ctrl.md
MILANO_CTRL -- requirements
Module: milano_ctrl

Interface
REQ-001 The block SHALL have parameter EXC_ADDR, default 32'h0000_0080, the exception handler address.
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 64, the maximum consecutive ex_busy_i cycles, range 2..255.
REQ-003 The block SHALL have port clk_i  input  1  the single clock, rising edge.
REQ-004 The block SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port fetch_enable_i  input  1  system run enable.
REQ-006 The block SHALL have port boot_addr_i  input  32  boot PC.
REQ-007 The block SHALL have ports branch_taken_ex_i  input  1 and branch_target_ex_i  input  32, for a branch resolved taken in EX and its target.
REQ-008 The block SHALL have port ex_busy_i  input  1  multicycle EX operation not done.
REQ-009 The block SHALL have ports ex_rd_addr_i  input  5, ex_rd_wr_en_i  input  1 and ex_is_load_i  input  1, describing the instruction in EX.
REQ-010 The block SHALL have ports id_rs1_addr_i  input  5, id_rs2_addr_i  input  5, id_rs1_used_i  input  1 and id_rs2_used_i  input  1, describing the ID source operands.
REQ-011 The block SHALL have ports illegal_instr_i  input  1 and id_pc_i  input  32, for an illegal decode in ID and its PC.
REQ-012 The block SHALL have ports pc_set_o  output  1 and pc_addr_o  output  32, a PC redirect pulse and its target.
REQ-013 The block SHALL have port fetch_enable_o  output  1  the IF fetch enable.
REQ-014 The block SHALL have ports stall_if_o  output  1 and stall_id_o  output  1, which hold the PC and the IF/ID register.
REQ-015 The block SHALL have ports flush_id_o  output  1 and flush_ex_o  output  1, which clear IF/ID and insert an ID/EX bubble.
REQ-016 The block SHALL have ports exc_pc_o  output  32, timeout_o  output  1, stall_cnt_o  output  32 and ctrl_state_o  output  3.

Function
REQ-017 The FSM SHALL use these states and ctrl_state_o encodings: RESET=0, BOOT_SET=1, RUN=2, WAIT_EX=3, FLUSH=4, HALT=5.
REQ-018 RESET SHALL go to BOOT_SET when fetch_enable_i=1; otherwise it SHALL stay. In RESET: fetch_enable_o=0, stall_if_o=1, stall_id_o=1.
REQ-019 BOOT_SET SHALL last 1 cycle with pc_set_o=1, pc_addr_o=boot_addr_i, flush_id_o=1, flush_ex_o=1, then go to RUN.
REQ-020 In RUN, fetch_enable_o SHALL be 1, and the RUN conditions SHALL be evaluated combinationally in the order given by REQ-021 to REQ-025, where only the first true condition acts.
REQ-021 RUN condition 1, branch_taken_ex_i: the block SHALL assert pc_set_o with pc_addr_o=branch_target_ex_i, assert flush_id_o and flush_ex_o, and stay in RUN; illegal_instr_i SHALL be ignored that cycle.
REQ-022 RUN condition 2, illegal_instr_i: the block SHALL assert pc_set_o with pc_addr_o=EXC_ADDR, assert flush_id_o and flush_ex_o, register exc_pc_o<=id_pc_i, and go to FLUSH.
REQ-023 RUN condition 3, ex_busy_i: the block SHALL assert stall_if_o and stall_id_o and go to WAIT_EX.
REQ-024 RUN condition 4, load-use hazard: the hazard SHALL be ex_is_load_i & ex_rd_wr_en_i & ex_rd_addr_i!=0 & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)); on it the block SHALL assert stall_if_o, stall_id_o and flush_ex_o for that cycle only and stay in RUN.
REQ-025 RUN condition 5, fetch_enable_i=0: the block SHALL go to HALT.
REQ-026 In WAIT_EX, stall_if_o=stall_id_o=1, and the 8-bit busy counter SHALL increment each cycle; the counter SHALL clear on entering RUN.
REQ-027 When ex_busy_i=0 in WAIT_EX, the block SHALL go to RUN; when the busy count reaches BUSY_TIMEOUT with ex_busy_i still 1, it SHALL set sticky timeout_o=1 and go to HALT.
REQ-028 FLUSH SHALL last 1 cycle with fetch_enable_o=0 and flush_id_o=1, then go to RUN.
REQ-029 In HALT, fetch_enable_o=0 and stall_if_o=stall_id_o=1; the block SHALL return to RUN, without pc_set_o, on fetch_enable_i=1 and timeout_o=0.
REQ-030 Once timeout_o=1, HALT SHALL be exited only by reset.
REQ-031 stall_cnt_o SHALL increment on every cycle that stall_id_o=1 in RUN or WAIT_EX, and SHALL saturate at 32'hFFFF_FFFF.
REQ-032 Outputs not named for a state SHALL be 0 in that state, and pc_addr_o SHALL be 0 when pc_set_o=0.

Reset
REQ-033 While rst_ni=0, the state SHALL be RESET immediately (asynchronously), and exc_pc_o, stall_cnt_o, timeout_o and the busy counter SHALL be 0.
REQ-034 While rst_ni=0, the outputs SHALL take the RESET-state values, and the first transition SHALL occur on the first rising clk_i edge after rst_ni rises.
REQ-035 Reset asserted in any state, including mid-WAIT_EX or mid-FLUSH, SHALL abort the operation with no pending pc_set_o.

Verification
REQ-036 Scenario, boot: release reset with fetch_enable_i=1 and boot_addr_i=32'h8000_0000 -> cycle 1 BOOT_SET with pc_set_o=1 and pc_addr_o=32'h8000_0000; cycle 2 RUN with fetch_enable_o=1.
REQ-037 Scenario, load-use: load with rd=5 in EX and id_rs2=5 used -> exactly 1 cycle of stall_if_o, stall_id_o and flush_ex_o, and stall_cnt_o +1; the same case with rd=0 -> no stall.
REQ-038 Scenario, branch and illegal in the same cycle: branch target 32'h100 -> pc_addr_o=32'h100, both flushes asserted, exc_pc_o unchanged, state stays RUN.
REQ-039 Scenario, illegal: illegal_instr_i with id_pc_i=32'h24 -> pc_addr_o=32'h80 and exc_pc_o=32'h24; next cycle FLUSH with fetch_enable_o=0; then RUN.
REQ-040 Scenario, busy: ex_busy_i held 3 cycles -> 3 stall cycles then RUN; ex_busy_i held 64 cycles -> timeout_o=1 and HALT, and a later fetch_enable_i toggle does not exit HALT.
REQ-041 Scenario, halt and reset: fetch_enable_i=0 in RUN -> HALT; fetch_enable_i=1 -> RUN with no pc_set_o; rst_ni=0 in WAIT_EX -> ctrl_state_o=0 and stall_cnt_o=0 before the next edge.
